// File: rtl/apb_shared_slave_arbiter.sv
// -----------------------------------------------------------------------------
// apb_shared_slave_arbiter
//
// Purpose:
//   Lets two APB masters share one APB slave port.
//   - M0 is the AHB-to-APB bridge path.
//   - M1 is a local configuration sequencer.
//   The master that wins arbitration has its transfer re-issued to the slave as
//   a registered SETUP/ACCESS sequence. The losing master is held off with
//   PREADY low until it gets its own grant.
//
// Arbitration:
//   Happens only in IDLE, on the PSEL0/PSEL1 values sampled at the clock edge.
//   - A single requester wins.
//   - On a tie the master other than the previous owner wins (round-robin).
//     M0 wins the first tie after reset.
//
// Handshake:
//   Strict APB valid/ready. A master request is PSELx=1. The request completes
//   in the cycle where that master sees PREADYx=1. On the slave side, PSELS0
//   and PENABLES advance IDLE -> SETUP -> ACCESS, and the arbiter stays in
//   ACCESS until PREADYS0=1.
//
// Optional feature (macro APB_ARB_TIMEOUT_EN):
//   When defined, an ACCESS phase that runs TIMEOUT_CYCLES cycles without
//   PREADYS0 is force-completed with PSLVERR=1 and PRDATA=0.
//   When undefined, ACCESS waits indefinitely.
//
// Ports:
//   ACLK, ARESET              clock, asynchronous active-high reset
//   PSEL0..PWDATA0            M0 request inputs
//   PRDATA0/PREADY0/PSLVERR0  M0 completion outputs
//   PSEL1..PWDATA1            M1 request inputs
//   PRDATA1/PREADY1/PSLVERR1  M1 completion outputs
//   PSELS0..PWDATAS           registered slave request outputs
//   PRDATAS0/PREADYS0/PSLVERRS0  slave completion inputs
//   GRANT                     index of the master owning the current/last transfer
// -----------------------------------------------------------------------------
module apb_shared_slave_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // master 0
    input  logic                  PSEL0,
    input  logic                  PENABLE0,
    input  logic                  PWRITE0,
    input  logic [ADDR_WIDTH-1:0] PADDR0,
    input  logic [DATA_WIDTH-1:0] PWDATA0,
    output logic [DATA_WIDTH-1:0] PRDATA0,
    output logic                  PREADY0,
    output logic                  PSLVERR0,
    // master 1
    input  logic                  PSEL1,
    input  logic                  PENABLE1,
    input  logic                  PWRITE1,
    input  logic [ADDR_WIDTH-1:0] PADDR1,
    input  logic [DATA_WIDTH-1:0] PWDATA1,
    output logic [DATA_WIDTH-1:0] PRDATA1,
    output logic                  PREADY1,
    output logic                  PSLVERR1,
    // slave side
    output logic                  PSELS0,
    output logic                  PENABLES,
    output logic                  PWRITES,
    output logic [ADDR_WIDTH-1:0] PADDRS,
    output logic [DATA_WIDTH-1:0] PWDATAS,
    input  logic [DATA_WIDTH-1:0] PRDATAS0,
    input  logic                  PREADYS0,
    input  logic                  PSLVERRS0,
    // arbitration status
    output logic                  GRANT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  last;
    logic                  last_nx;
    logic                  grant_nx;
    logic                  psels_nx;
    logic                  penables_nx;
    logic                  pwrites_nx;
    logic [ADDR_WIDTH-1:0] paddrs_nx;
    logic [DATA_WIDTH-1:0] pwdatas_nx;

    logic winner;
    logic in_access;
    logic timeout_hit;
    logic done;
    logic sel0;
    logic sel1;

    // PENABLEx is protocol-only and plays no part in arbitration.
    // Sinking it here keeps the port list complete without dangling inputs.
    logic unused_sink;
    assign unused_sink = &{1'b0, PENABLE0, PENABLE1, (TIMEOUT_CYCLES > 1)};

    // Tie-break favours the master that did not own the previous transfer.
    assign winner    = (PSEL0 && PSEL1) ? ~last : PSEL1;
    assign in_access = (state == ST_ACCESS);

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;

    // Counts ACCESS cycles without PREADYS0.
    // The counter is cleared in SETUP, so it reads 0 in the first ACCESS cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= '0;
        end else if (in_access && !PREADYS0 && !timeout_hit) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // A real PREADYS0 in the same cycle wins over the forced completion.
    assign timeout_hit = in_access && !PREADYS0 && (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    assign done = in_access && (PREADYS0 || timeout_hit);

    // Completion is routed combinationally to the granted master only.
    assign sel0 = in_access && !GRANT;
    assign sel1 = in_access &&  GRANT;

    assign PREADY0  = sel0 && (PREADYS0 || timeout_hit);
    assign PSLVERR0 = sel0 && (PSLVERRS0 || timeout_hit);
    assign PRDATA0  = (sel0 && !timeout_hit) ? PRDATAS0 : '0;

    assign PREADY1  = sel1 && (PREADYS0 || timeout_hit);
    assign PSLVERR1 = sel1 && (PSLVERRS0 || timeout_hit);
    assign PRDATA1  = (sel1 && !timeout_hit) ? PRDATAS0 : '0;

    // Next-state and next-value logic for the FSM and the slave-side registers.
    always_comb begin
        state_nx    = state;
        last_nx     = last;
        grant_nx    = GRANT;
        psels_nx    = PSELS0;
        penables_nx = PENABLES;
        pwrites_nx  = PWRITES;
        paddrs_nx   = PADDRS;
        pwdatas_nx  = PWDATAS;

        case (state)
            ST_IDLE: begin
                if (PSEL0 || PSEL1) begin
                    // Win edge: the slave registers update only here.
                    grant_nx    = winner;
                    psels_nx    = 1'b1;
                    penables_nx = 1'b0;
                    pwrites_nx  = winner ? PWRITE1 : PWRITE0;
                    paddrs_nx   = winner ? PADDR1  : PADDR0;
                    pwdatas_nx  = winner ? PWDATA1 : PWDATA0;
                    state_nx    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penables_nx = 1'b1;
                state_nx    = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (done) begin
                    psels_nx    = 1'b0;
                    penables_nx = 1'b0;
                    last_nx     = GRANT;
                    state_nx    = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            GRANT    <= 1'b0;
            PSELS0   <= 1'b0;
            PENABLES <= 1'b0;
            PWRITES  <= 1'b0;
            PADDRS   <= '0;
            PWDATAS  <= '0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            GRANT    <= grant_nx;
            PSELS0   <= psels_nx;
            PENABLES <= penables_nx;
            PWRITES  <= pwrites_nx;
            PADDRS   <= paddrs_nx;
            PWDATAS  <= pwdatas_nx;
        end
    end

endmodule

// File: tb/tb_apb_shared_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_shared_slave_arbiter
//
// Purpose:
//   Directed bench for apb_shared_slave_arbiter.
//
// Stimulus timing:
//   - Inputs are driven 2 time units after each rising edge.
//   - Outputs are checked 1 time unit after that.
//
// Expected values:
//   All expected values are hand-computed constants.
//
// Optional feature:
//   With APB_ARB_TIMEOUT_EN defined, the DUT is built with TIMEOUT_CYCLES=8
//   and the timeout step is included.
// -----------------------------------------------------------------------------
module tb_apb_shared_slave_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    // ---------------- clock / reset ----------------
    logic ACLK;
    logic ARESET;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- DUT signals ----------------
    logic          PSEL0, PENABLE0, PWRITE0;
    logic [AW-1:0] PADDR0;
    logic [DW-1:0] PWDATA0, PRDATA0;
    logic          PREADY0, PSLVERR0;
    logic          PSEL1, PENABLE1, PWRITE1;
    logic [AW-1:0] PADDR1;
    logic [DW-1:0] PWDATA1, PRDATA1;
    logic          PREADY1, PSLVERR1;
    logic          PSELS0, PENABLES, PWRITES;
    logic [AW-1:0] PADDRS;
    logic [DW-1:0] PWDATAS, PRDATAS0;
    logic          PREADYS0, PSLVERRS0;
    logic          GRANT;

    apb_shared_slave_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .PSEL0    (PSEL0),
        .PENABLE0 (PENABLE0),
        .PWRITE0  (PWRITE0),
        .PADDR0   (PADDR0),
        .PWDATA0  (PWDATA0),
        .PRDATA0  (PRDATA0),
        .PREADY0  (PREADY0),
        .PSLVERR0 (PSLVERR0),
        .PSEL1    (PSEL1),
        .PENABLE1 (PENABLE1),
        .PWRITE1  (PWRITE1),
        .PADDR1   (PADDR1),
        .PWDATA1  (PWDATA1),
        .PRDATA1  (PRDATA1),
        .PREADY1  (PREADY1),
        .PSLVERR1 (PSLVERR1),
        .PSELS0   (PSELS0),
        .PENABLES (PENABLES),
        .PWRITES  (PWRITES),
        .PADDRS   (PADDRS),
        .PWDATAS  (PWDATAS),
        .PRDATAS0 (PRDATAS0),
        .PREADYS0 (PREADYS0),
        .PSLVERRS0(PSLVERRS0),
        .GRANT    (GRANT)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        ARESET   = 1'b1;
        PSEL0    = 1'b0; PENABLE0 = 1'b0; PWRITE0 = 1'b0; PADDR0 = '0; PWDATA0 = '0;
        PSEL1    = 1'b0; PENABLE1 = 1'b0; PWRITE1 = 1'b0; PADDR1 = '0; PWDATA1 = '0;
        PRDATAS0 = '0;   PREADYS0 = 1'b1; PSLVERRS0 = 1'b0;

        // -------- reset state --------
        repeat (2) tick();
        #1;
        chk("rst_grant",    GRANT,    1'b0);
        chk("rst_psels",    PSELS0,   1'b0);
        chk("rst_penables", PENABLES, 1'b0);
        chk("rst_pwrites",  PWRITES,  1'b0);
        chk("rst_paddrs",   PADDRS,   32'h0);
        chk("rst_pwdatas",  PWDATAS,  32'h0);
        chk("rst_pready0",  PREADY0,  1'b0);
        chk("rst_pready1",  PREADY1,  1'b0);

        // -------- tie after reset: M0 write first, then M1 read of 0x20 --------
        ARESET   = 1'b0;
        PSEL0    = 1'b1; PWRITE0 = 1'b1; PADDR0 = 32'h100; PWDATA0 = 32'h1111_1111;
        PSEL1    = 1'b1; PWRITE1 = 1'b0; PADDR1 = 32'h20;
        PRDATAS0 = 32'h1234_5678;

        tick(); #1;  // SETUP for M0
        chk("tie_grant_m0",   GRANT,    1'b0);
        chk("tie_paddrs_m0",  PADDRS,   32'h100);
        chk("tie_pwrites_m0", PWRITES,  1'b1);
        chk("tie_setup_pen",  PENABLES, 1'b0);
        chk("tie_setup_rdy0", PREADY0,  1'b0);

        PENABLE0 = 1'b1;
        tick(); #1;  // ACCESS for M0
        chk("tie_acc_rdy0",    PREADY0, 1'b1);
        chk("tie_acc_rdy1",    PREADY1, 1'b0);
        chk("tie_acc_prdata0", PRDATA0, 32'h1234_5678);
        chk("tie_acc_prdata1", PRDATA1, 32'h0);

        tick();      // IDLE
        PSEL0 = 1'b0; PENABLE0 = 1'b0;
        #1;
        chk("tie_idle_psels", PSELS0,  1'b0);
        chk("tie_idle_grant", GRANT,   1'b0);
        chk("tie_idle_rdy1",  PREADY1, 1'b0);

        tick(); #1;  // SETUP for M1
        chk("tie_grant_m1",   GRANT,   1'b1);
        chk("tie_paddrs_m1",  PADDRS,  32'h20);
        chk("tie_pwrites_m1", PWRITES, 1'b0);
        chk("tie_psels_m1",   PSELS0,  1'b1);

        PENABLE1 = 1'b1;
        tick(); #1;  // ACCESS for M1
        chk("tie_m1_rdy1",    PREADY1,  1'b1);
        chk("tie_m1_prdata1", PRDATA1,  32'h1234_5678);
        chk("tie_m1_slverr1", PSLVERR1, 1'b0);
        chk("tie_m1_rdy0",    PREADY0,  1'b0);

        // -------- both continuously requesting: grants alternate 0,1,0,1,0,1 --------
        tick();      // IDLE
        PSEL0  = 1'b1; PWRITE0 = 1'b1; PADDR0 = 32'h300; PWDATA0 = 32'hA0;
        PSEL1  = 1'b1; PWRITE1 = 1'b1; PADDR1 = 32'h400; PWDATA1 = 32'hB1;
        PENABLE1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic g;
            g = k[0];
            tick(); #1;  // SETUP
            chk("rr_grant",  GRANT,  g);
            chk("rr_paddrs", PADDRS, g ? 32'h400 : 32'h300);
            chk("rr_psels",  PSELS0, 1'b1);
            tick(); #1;  // ACCESS
            chk("rr_rdy0",   PREADY0, !g);
            chk("rr_rdy1",   PREADY1, g);
            tick(); #1;  // IDLE
            chk("rr_idle_psels", PSELS0, 1'b0);
            chk("rr_idle_grant", GRANT,  g);
        end
        PSEL0 = 1'b0; PSEL1 = 1'b0;

        // -------- single M0 write, zero-wait slave --------
        tick();      // IDLE
        PSEL0 = 1'b1; PENABLE0 = 1'b0; PWRITE0 = 1'b1;
        PADDR0 = 32'h0000_0010; PWDATA0 = 32'hA5A5_0001;
        PRDATAS0 = 32'hDEAD_BEEF;

        tick(); #1;  // T+1 SETUP
        chk("wr_psels",   PSELS0,   1'b1);
        chk("wr_pen_t1",  PENABLES, 1'b0);
        chk("wr_paddrs",  PADDRS,   32'h10);
        chk("wr_pwdatas", PWDATAS,  32'hA5A5_0001);
        chk("wr_pwrites", PWRITES,  1'b1);
        chk("wr_rdy0_t1", PREADY0,  1'b0);

        PENABLE0 = 1'b1;
        tick(); #1;  // T+2 ACCESS
        chk("wr_pen_t2",  PENABLES, 1'b1);
        chk("wr_rdy0_t2", PREADY0,  1'b1);
        chk("wr_rdy1_t2", PREADY1,  1'b0);
        chk("wr_err0_t2", PSLVERR0, 1'b0);

        tick();      // IDLE
        PSEL0 = 1'b0; PENABLE0 = 1'b0;
        PADDR0 = 32'hFFFF_FFFF;
        #1;
        chk("wr_idle_psels", PSELS0,   1'b0);
        chk("wr_idle_pen",   PENABLES, 1'b0);
        chk("wr_hold_paddr", PADDRS,   32'h10);

        // -------- M1 read with 3 wait states then error; M0 held off --------
        PSEL1 = 1'b1; PWRITE1 = 1'b0; PADDR1 = 32'h44;
        PREADYS0 = 1'b0; PSLVERRS0 = 1'b0; PRDATAS0 = 32'hCAFE_F00D;

        tick();      // SETUP for M1
        PSEL0 = 1'b1; PWRITE0 = 1'b0; PADDR0 = 32'h500;
        #1;
        chk("ws_grant", GRANT, 1'b1);

        PENABLE1 = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick(); #1;  // ACCESS wait cycles
            chk("ws_wait_rdy1", PREADY1, 1'b0);
            chk("ws_wait_rdy0", PREADY0, 1'b0);
        end

        PREADYS0 = 1'b1; PSLVERRS0 = 1'b1;
        #1;
        chk("ws_done_rdy1",    PREADY1,  1'b1);
        chk("ws_done_err1",    PSLVERR1, 1'b1);
        chk("ws_done_prdata1", PRDATA1,  32'hCAFE_F00D);
        chk("ws_done_rdy0",    PREADY0,  1'b0);
        chk("ws_done_err0",    PSLVERR0, 1'b0);

        tick();      // IDLE
        PSEL1 = 1'b0; PENABLE1 = 1'b0; PSLVERRS0 = 1'b0;
        #1;
        chk("ws_idle_rdy0", PREADY0, 1'b0);

        tick(); #1;  // SETUP for M0
        chk("ws_m0_grant",  GRANT,  1'b1 ^ 1'b1);
        chk("ws_m0_paddrs", PADDRS, 32'h500);

        PENABLE0 = 1'b1;
        tick(); #1;  // ACCESS for M0
        chk("ws_m0_rdy0", PREADY0,  1'b1);
        chk("ws_m0_err0", PSLVERR0, 1'b0);

        tick();      // IDLE
        PSEL0 = 1'b0; PENABLE0 = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
        // -------- slave never ready: forced error completion --------
        PSEL0 = 1'b1; PWRITE0 = 1'b0; PADDR0 = 32'h80;
        PREADYS0 = 1'b0; PRDATAS0 = 32'hFFFF_0000;
        tick();      // SETUP
        PENABLE0 = 1'b1;
        tick();      // first ACCESS cycle
        for (int i = 1; i < 8; i++) begin
            #1;
            chk("to_wait_rdy0", PREADY0, 1'b0);
            tick();
        end
        #1;          // eighth ACCESS cycle
        chk("to_rdy0",    PREADY0,  1'b1);
        chk("to_err0",    PSLVERR0, 1'b1);
        chk("to_prdata0", PRDATA0,  32'h0);
        tick(); #1;
        chk("to_psels", PSELS0, 1'b0);
        PSEL0 = 1'b0; PENABLE0 = 1'b0; PREADYS0 = 1'b1;
        tick();
`endif

        // -------- asynchronous reset during ACCESS --------
        PSEL1 = 1'b1; PWRITE1 = 1'b1; PADDR1 = 32'h66; PWDATA1 = 32'h77;
        PREADYS0 = 1'b0;
        tick();      // SETUP
        PENABLE1 = 1'b1;
        tick(); #1;  // ACCESS
        chk("ar_pre_pen",   PENABLES, 1'b1);
        chk("ar_pre_grant", GRANT,    1'b1);

        PREADYS0 = 1'b1;
        ARESET   = 1'b1;
        #1;
        chk("ar_psels",   PSELS0,   1'b0);
        chk("ar_pen",     PENABLES, 1'b0);
        chk("ar_pwrites", PWRITES,  1'b0);
        chk("ar_paddrs",  PADDRS,   32'h0);
        chk("ar_pwdatas", PWDATAS,  32'h0);
        chk("ar_grant",   GRANT,    1'b0);
        chk("ar_rdy1",    PREADY1,  1'b0);
        chk("ar_prdata1", PRDATA1,  32'h0);

        tick();
        ARESET = 1'b0;
        PSEL0 = 1'b1; PWRITE0 = 1'b1; PADDR0 = 32'h90; PENABLE0 = 1'b0;
        PSEL1 = 1'b1; PENABLE1 = 1'b0;
        tick(); #1;  // first tie after reset goes to M0
        chk("ar_tie_grant",  GRANT,  1'b0);
        chk("ar_tie_paddrs", PADDRS, 32'h90);
        PENABLE0 = 1'b1;
        tick(); #1;
        chk("ar_tie_rdy0", PREADY0, 1'b1);
        chk("ar_tie_rdy1", PREADY1, 1'b0);
        tick();
        PSEL0 = 1'b0; PSEL1 = 1'b0; PENABLE0 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
